// File: rtl/button_event_ctrl.sv
// Classifies debounced button presses as single/double, arbitrates them round-robin
// and queues the resulting events in a small first-word-fall-through FIFO.
module button_event_ctrl #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned WINDOW     = 25_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic             enable,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_double,
    output logic             fifo_full,
    output logic [7:0]       drop_count
);

    localparam int unsigned CNT_W = $clog2(WINDOW);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_PEND = 2'd2
    } btn_state_e;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            dbl;
    } evt_t;

    // Per-button classifier state
    btn_state_e       state_q [N_BTN];
    btn_state_e       state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    logic [N_BTN-1:0] type_q, type_d;
    logic [N_BTN-1:0] pulse, pend, drop_vec;

    // Arbiter
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [N_BTN-1:0] eligible, rr_mask, sel_hi, sel, grant;
    logic             grant_any, grant_dbl, can_grant;
    logic [ID_W-1:0]  grant_idx;

    // Event FIFO and registered outputs
    evt_t             mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d, remain;
    logic             push, pop;
    evt_t             push_data, head_d;
    logic             valid_q, full_q, dbl_q;
    logic [ID_W-1:0]  id_q;
    logic [7:0]       drop_q, drop_d;
    logic [15:0]      drop_sum;

    assign pulse = btn_pulse & {N_BTN{enable}};

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            pend[i] = (state_q[i] == S_PEND);
        end
    end

    // Round-robin arbiter: prefer PEND buttons at or above the pointer, else wrap to the lowest.
    always_comb begin
        pop       = valid_q & evt_ready;
        can_grant = ~full_q | pop;
        eligible  = pend & {N_BTN{can_grant}};
        for (int i = 0; i < N_BTN; i++) begin
            rr_mask[i] = (ID_W'(i) >= rr_q);
        end
        sel_hi    = eligible & rr_mask;
        sel       = (|sel_hi) ? sel_hi : eligible;
        grant_any = |sel;
        grant_idx = '0;
        grant_dbl = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (sel[i]) begin
                grant_idx = ID_W'(i);
                grant_dbl = type_q[i];
            end
        end
        for (int i = 0; i < N_BTN; i++) begin
            grant[i] = grant_any && (ID_W'(i) == grant_idx);
        end
        rr_d = rr_q;
        if (grant_any) begin
            rr_d = (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Per-button next state: IDLE -> WAIT -> PEND -> (grant) IDLE or a fresh WAIT
    always_comb begin
        type_d   = type_q;
        drop_vec = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (pulse[i]) begin
                        state_d[i] = S_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                S_WAIT: begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    if (pulse[i]) begin
                        state_d[i] = S_PEND;
                        type_d[i]  = 1'b1;
                    end else if (cnt_q[i] == CNT_W'(WINDOW - 1)) begin
                        state_d[i] = S_PEND;
                        type_d[i]  = 1'b0;
                    end
                end
                S_PEND: begin
                    if (grant[i]) begin
                        state_d[i] = pulse[i] ? S_WAIT : S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (pulse[i]) begin
                        drop_vec[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase
        end
    end

    // Several buttons may drop in one cycle; sum them and saturate.
    always_comb begin
        drop_sum = 16'(drop_q);
        for (int i = 0; i < N_BTN; i++) begin
            drop_sum = drop_sum + 16'(drop_vec[i]);
        end
        drop_d = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
    end

    // FIFO bookkeeping; the head register is loaded from the post-edge FIFO contents.
    always_comb begin
        push         = grant_any;
        push_data.id = grant_idx;
        push_data.dbl = grant_dbl;
        count_d      = count_q + CW'(push) - CW'(pop);
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        remain       = count_q - CW'(pop);
        head_d       = '0;
        if (remain == '0) begin
            if (push) begin
                head_d = push_data;
            end
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            type_q   <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            id_q     <= '0;
            dbl_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            type_q   <= type_d;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            full_q   <= (count_d == CW'(FIFO_DEPTH));
            id_q     <= head_d.id;
            dbl_q    <= head_d.dbl;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign evt_valid  = valid_q;
    assign evt_id     = id_q;
    assign evt_double = dbl_q;
    assign fifo_full  = full_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl with a short double-press window.
module tb_button_event_ctrl;

    localparam int unsigned N_BTN      = 4;
    localparam int unsigned ID_W       = 2;
    localparam int unsigned WINDOW     = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N_BTN-1:0] btn_pulse = '0;
    logic             enable = 1'b1;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [ID_W-1:0]  evt_id;
    logic             evt_double;
    logic             fifo_full;
    logic [7:0]       drop_count;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            dbl;
    } exp_evt_t;

    exp_evt_t sb[$];
    exp_evt_t mon_e;
    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int cyc      = 0;
    int pops0    = 0;

    button_event_ctrl #(
        .N_BTN(N_BTN), .ID_W(ID_W), .WINDOW(WINDOW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .btn_pulse(btn_pulse), .enable(enable),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_double(evt_double), .fifo_full(fifo_full), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick(1);
    endtask

    task automatic pulse_at(input int n, input logic [N_BTN-1:0] m);
        wait_cyc(n);
        btn_pulse = m;
        tick(1);
        btn_pulse = '0;
    endtask

    task automatic exp_push(input logic [ID_W-1:0] id, input logic dbl);
        sb.push_back({id, dbl});
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        btn_pulse = '0;
        tick(1);
        sb.delete();
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Handshake happens at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            n_pops++;
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check_eq("evt_id", 32'(evt_id), 32'(mon_e.id));
                check_eq("evt_double", 32'(evt_double), 32'(mon_e.dbl));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // 1: single press, held head, drop on accept
        do_reset();
        evt_ready = 1'b0;
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_id", 32'(evt_id), 32'd0);
        check_eq("rst_double", 32'(evt_double), 32'd0);
        check_eq("rst_full", 32'(fifo_full), 32'd0);
        check_eq("rst_drop", 32'(drop_count), 32'd0);
        exp_push(2'd2, 1'b0);
        pulse_at(10, 4'b0100);
        wait_cyc(19); check_eq("t1_valid_19", 32'(evt_valid), 32'd0);
        wait_cyc(20); check_eq("t1_valid_20", 32'(evt_valid), 32'd1);
        check_eq("t1_id_20", 32'(evt_id), 32'd2);
        check_eq("t1_dbl_20", 32'(evt_double), 32'd0);
        wait_cyc(22); check_eq("t1_hold_valid", 32'(evt_valid), 32'd1);
        check_eq("t1_hold_id", 32'(evt_id), 32'd2);
        wait_cyc(23); evt_ready = 1'b1;
        tick(1); check_eq("t1_valid_after", 32'(evt_valid), 32'd0);
        tick(5); check_eq("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2a: double press well inside the window
        do_reset();
        evt_ready = 1'b1;
        pops0 = n_pops;
        exp_push(2'd1, 1'b1);
        pulse_at(10, 4'b0010);
        pulse_at(14, 4'b0010);
        wait_cyc(15); check_eq("t2a_valid_15", 32'(evt_valid), 32'd0);
        wait_cyc(16); check_eq("t2a_valid_16", 32'(evt_valid), 32'd1);
        check_eq("t2a_dbl", 32'(evt_double), 32'd1);
        wait_cyc(35); check_eq("t2a_one_event", 32'(n_pops - pops0), 32'd1);

        // 2b: second press on the expiry cycle still counts as double
        do_reset();
        exp_push(2'd1, 1'b1);
        pulse_at(10, 4'b0010);
        pulse_at(18, 4'b0010);
        wait_cyc(19); check_eq("t2b_valid_19", 32'(evt_valid), 32'd0);
        wait_cyc(20); check_eq("t2b_valid_20", 32'(evt_valid), 32'd1);
        check_eq("t2b_dbl", 32'(evt_double), 32'd1);
        wait_cyc(30); check_eq("t2b_sb_empty", 32'(sb.size()), 32'd0);

        // 2c: second press one cycle late -> single, plus a new window
        do_reset();
        exp_push(2'd1, 1'b0);
        exp_push(2'd1, 1'b0);
        pulse_at(10, 4'b0010);
        pulse_at(19, 4'b0010);
        wait_cyc(20); check_eq("t2c_valid_20", 32'(evt_valid), 32'd1);
        check_eq("t2c_dbl_20", 32'(evt_double), 32'd0);
        wait_cyc(28); check_eq("t2c_valid_28", 32'(evt_valid), 32'd0);
        wait_cyc(29); check_eq("t2c_valid_29", 32'(evt_valid), 32'd1);
        wait_cyc(35); check_eq("t2c_sb_empty", 32'(sb.size()), 32'd0);

        // 3: simultaneous presses drained in round-robin order, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) exp_push(ID_W'(k), 1'b0);
            pulse_at(10 + 30 * r, 4'b1111);
            for (int k = 0; k < 4; k++) begin
                wait_cyc(20 + 30 * r + k);
                check_eq("t3_valid", 32'(evt_valid), 32'd1);
                check_eq("t3_order", 32'(evt_id), 32'(k));
            end
        end
        wait_cyc(80); check_eq("t3_sb_empty", 32'(sb.size()), 32'd0);

        // 4: FIFO full, pending button, drop, then drain with push during pop
        do_reset();
        evt_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_push(ID_W'(k), 1'b0);
        exp_push(2'd0, 1'b0);
        pulse_at(10, 4'b1111);
        pulse_at(21, 4'b0001);
        wait_cyc(22); check_eq("t4_full_22", 32'(fifo_full), 32'd0);
        wait_cyc(23); check_eq("t4_full_23", 32'(fifo_full), 32'd1);
        wait_cyc(32); check_eq("t4_head_id", 32'(evt_id), 32'd0);
        check_eq("t4_drop_before", 32'(drop_count), 32'd0);
        pulse_at(33, 4'b0001);
        check_eq("t4_drop_1", 32'(drop_count), 32'd1);
        wait_cyc(36); evt_ready = 1'b1;
        check_eq("t4_full_36", 32'(fifo_full), 32'd1);
        tick(1); check_eq("t4_full_pushpop", 32'(fifo_full), 32'd1);
        wait_cyc(41); check_eq("t4_valid_41", 32'(evt_valid), 32'd0);
        wait_cyc(42); check_eq("t4_drop_final", 32'(drop_count), 32'd1);
        check_eq("t4_full_final", 32'(fifo_full), 32'd0);
        check_eq("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: enable gating
        do_reset();
        evt_ready = 1'b1;
        enable = 1'b0;
        pulse_at(10, 4'b1000);
        wait_cyc(20); check_eq("t5_no_evt", 32'(evt_valid), 32'd0);
        check_eq("t5_no_drop", 32'(drop_count), 32'd0);
        enable = 1'b1;
        exp_push(2'd3, 1'b0);
        pulse_at(30, 4'b1000);
        wait_cyc(33); enable = 1'b0;
        pulse_at(35, 4'b1000);
        wait_cyc(39); check_eq("t5_valid_39", 32'(evt_valid), 32'd0);
        wait_cyc(40); check_eq("t5_valid_40", 32'(evt_valid), 32'd1);
        check_eq("t5_id", 32'(evt_id), 32'd3);
        wait_cyc(50); enable = 1'b1;
        check_eq("t5_sb_empty", 32'(sb.size()), 32'd0);

        // 6: reset mid-window with queued events, then drop saturation
        do_reset();
        evt_ready = 1'b0;
        exp_push(2'd1, 1'b0);
        exp_push(2'd2, 1'b0);
        pulse_at(2, 4'b0010);
        pulse_at(3, 4'b0100);
        pulse_at(14, 4'b0001);
        wait_cyc(15); check_eq("t6_valid_pre", 32'(evt_valid), 32'd1);
        wait_cyc(16);
        do_reset();
        check_eq("t6_valid_rst", 32'(evt_valid), 32'd0);
        check_eq("t6_drop_rst", 32'(drop_count), 32'd0);
        check_eq("t6_full_rst", 32'(fifo_full), 32'd0);
        evt_ready = 1'b1;
        pops0 = n_pops;
        tick(30);
        check_eq("t6_no_evt", 32'(n_pops - pops0), 32'd0);

        do_reset();
        evt_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_push(ID_W'(k), 1'b0);
        exp_push(2'd0, 1'b0);
        pulse_at(2, 4'b1111);
        pulse_at(12, 4'b0001);
        wait_cyc(24);
        btn_pulse = 4'b0001;
        tick(100);
        check_eq("t6_drop_100", 32'(drop_count), 32'd100);
        tick(200);
        btn_pulse = '0;
        check_eq("t6_drop_sat", 32'(drop_count), 32'd255);
        evt_ready = 1'b1;
        tick(20);
        check_eq("t6_drain_valid", 32'(evt_valid), 32'd0);
        check_eq("t6_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("t6_drop_hold", 32'(drop_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
Collects 1-clock press pulses from N_BTN debounced buttons. Classifies each press as a single or a double press using a per-button time window. Arbitrates the resulting events round-robin into a small first-word-fall-through event FIFO that is drained by the application FSM through a valid/ready handshake. Sits between the per-button debouncers and the top-level control logic.

Parameters:
N_BTN, 4, number of button inputs
ID_W, 2, width of the event button index (must satisfy 2^ID_W >= N_BTN)
WINDOW, 25_000_000, double-press window in clk cycles (250 ms at 100 MHz); must be >= 2
FIFO_DEPTH, 4, event FIFO entries (power of 2)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
btn_pulse  input  N_BTN  1-clk press pulses from the debouncers; bit i = button i
enable  input  1  when 0, new pulses are ignored; in-flight state still completes
evt_valid  output  1  FIFO head holds an event
evt_ready  input  1  consumer accepts the head event
evt_id  output  ID_W  button index of the head event
evt_double  output  1  1 = double press, 0 = single press
fifo_full  output  1  event FIFO full
drop_count  output  8  count of dropped presses, saturates at 255

Behaviour:
- Reset (synchronous, takes priority): all button FSMs go to IDLE, window counters 0, FIFO empty, RR pointer 0, drop_count 0. Outputs: evt_valid=0, evt_id=0, evt_double=0, fifo_full=0. Reset mid-window or mid-handshake discards all state; no event is emitted.
- A pulse counts only when btn_pulse[i]=1 and enable=1. Pulses seen while enable=0 are not counted as drops.
- Per-button FSM, states IDLE / WAIT / PEND, with a window counter and a pend_type bit:
  - IDLE: on pulse -> WAIT, counter=0.
  - WAIT: counter increments each cycle.
    - On pulse -> PEND, type=double.
    - Else if counter==WINDOW-1 -> PEND, type=single.
    - Pulse and expiry in the same cycle: double wins.
  - PEND: hold until granted.
    - Grant with no pulse -> IDLE.
    - Grant and pulse in the same cycle -> WAIT, counter=0.
    - Pulse without grant -> press dropped, drop_count+1 (saturating); state unchanged.
- Arbiter (combinational grant, at most one per cycle):
  - Grants among buttons in PEND when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Round-robin search starts at the RR pointer; after a grant, pointer = granted index + 1, wrapping at N_BTN.
  - The pointer is unchanged when nothing is granted.
- FIFO:
  - A grant pushes {id, type} at the clock edge.
  - pop = evt_valid & evt_ready.
  - evt_valid = not empty. evt_id and evt_double are driven from the head entry, registered, and stable while evt_valid=1 and evt_ready=0.
  - Simultaneous push and pop is legal at any occupancy, including full; occupancy is then unchanged.
  - fifo_full = (count == FIFO_DEPTH).
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency, no contention, consumer ready:
  - Single press: pulse at cycle t -> WAIT at t+1 -> PEND at t+WINDOW+1 -> evt_valid at t+WINDOW+2.
  - Double press: second pulse at cycle u -> PEND at u+1 -> evt_valid at u+2.
- Presses are never lost silently. Each press either contributes to an event or increments drop_count. The first press of a double pair does not produce its own event.

Test Plan (WINDOW=8, N_BTN=4, FIFO_DEPTH=4):
1. Reset, then a single pulse on btn 2 at cycle 10 -> evt_valid rises at cycle 20 with evt_id=2, evt_double=0; the event holds until evt_ready=1, and evt_valid=0 the following cycle.
2. Pulses on btn 1 at cycles 10 and 14 -> exactly one event, evt_id=1, evt_double=1, evt_valid at cycle 16. Repeat with the second pulse at cycle 18 (the expiry cycle) -> double. With the second pulse at cycle 19 -> single event, and a new window is opened.
3. All four buttons pulsed in cycle 10 with evt_ready=1 -> four single events in order 0,1,2,3 on consecutive cycles. Repeat once more -> order 0,1,2,3 again, because the RR pointer has wrapped to 0.
4. evt_ready=0; single presses on buttons 0..3 and then button 0 again -> fifo_full=1 after 4 events, btn 0 stays in PEND. A further btn 0 pulse while in PEND -> drop_count=1. Raise evt_ready -> 5 events drain, pushes during pops are accepted, and no extra drops occur.
5. enable=0, pulse btn 3 -> no event and drop_count unchanged. Pulse btn 3 with enable=1, drop enable mid-window -> the single event is still emitted.
6. Assert reset while btn 0 is in WAIT and the FIFO holds 2 entries -> next cycle evt_valid=0 and drop_count=0, and no event is emitted afterwards. Drive 300 dropped presses -> drop_count=255.
